nasti_read_burst_splitter: RTL and testbench

- Sits directly upstream of the width-narrowing read converter on the NASTI read path.
- Chops long INCR read bursts into sub-bursts of at most MAX_BEATS beats, so the narrower's per-burst size limit is never exceeded.
- Recombines the sub-burst read data into one response stream toward the master.
- Handles a single outstanding transaction and adds no buffering on the R data path.

---
 rtl/nasti_read_burst_splitter.sv | 160 ++++++++++++++++
 tb/tb_nasti_read_burst_splitter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_read_burst_splitter.sv
// Splits INCR NASTI read bursts into sub-bursts of at most MAX_BEATS beats and merges their R beats
// back into one response stream; one transaction in flight. Define SPLIT_4K_EN to also split at 4 KiB.
module nasti_read_burst_splitter #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int MAX_BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ID_WIDTH-1:0]     master_ar_id,
  input  logic [ADDR_WIDTH-1:0]   master_ar_addr,
  input  logic [7:0]              master_ar_len,
  input  logic [2:0]              master_ar_size,
  input  logic [1:0]              master_ar_burst,
  input  logic [14+USER_WIDTH:0]  master_ar_side,
  input  logic                    master_ar_valid,
  output logic                    master_ar_ready,
  output logic [ID_WIDTH-1:0]     master_r_id,
  output logic [DATA_WIDTH-1:0]   master_r_data,
  output logic [1:0]              master_r_resp,
  output logic                    master_r_last,
  output logic                    master_r_valid,
  input  logic                    master_r_ready,
  output logic [ID_WIDTH-1:0]     slave_ar_id,
  output logic [ADDR_WIDTH-1:0]   slave_ar_addr,
  output logic [7:0]              slave_ar_len,
  output logic [2:0]              slave_ar_size,
  output logic [1:0]              slave_ar_burst,
  output logic [14+USER_WIDTH:0]  slave_ar_side,
  output logic                    slave_ar_valid,
  input  logic                    slave_ar_ready,
  input  logic [DATA_WIDTH-1:0]   slave_r_data,
  input  logic [1:0]              slave_r_resp,
  input  logic                    slave_r_last,
  input  logic                    slave_r_valid,
  output logic                    slave_r_ready
);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [8:0] MAX_B      = 9'(MAX_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [14+USER_WIDTH:0]  side_q, side_d;
  logic [8:0]              rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    final_q, final_d;
  logic [8:0]              beats;
  logic                    in_r;

  // Beats in the sub-burst about to be issued; non-INCR bursts go out whole.
`ifdef SPLIT_4K_EN
  logic [12:0] to_4k;
  always_comb begin
    to_4k = (13'h1000 - {1'b0, addr_q[11:0]}) >> size_q;
    beats = rem_q;
    if (burst_q == BURST_INCR) begin
      if (beats > MAX_B) beats = MAX_B;
      if ({4'b0, beats} > to_4k) beats = to_4k[8:0];
    end
  end
`else
  always_comb begin
    beats = rem_q;
    if (burst_q == BURST_INCR && rem_q > MAX_B) beats = MAX_B;
  end
`endif

  assign in_r = (state_q == S_R);

  assign master_ar_ready = (state_q == S_IDLE);
  assign slave_ar_valid  = (state_q == S_AR);
  assign slave_ar_id     = id_q;
  assign slave_ar_addr   = addr_q;
  assign slave_ar_len    = 8'(beats - 9'd1);
  assign slave_ar_size   = size_q;
  assign slave_ar_burst  = burst_q;
  assign slave_ar_side   = side_q;

  // R channel is a zero-latency pass-through gated by the state.
  assign master_r_valid  = in_r & slave_r_valid;
  assign slave_r_ready   = in_r & master_r_ready;
  assign master_r_last   = in_r & slave_r_last & final_q;
  assign master_r_data   = slave_r_data;
  assign master_r_resp   = slave_r_resp;
  assign master_r_id     = id_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    size_d  = size_q;
    burst_d = burst_q;
    side_d  = side_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    final_d = final_q;
    case (state_q)
      S_IDLE: begin
        if (master_ar_valid) begin
          id_d    = master_ar_id;
          size_d  = master_ar_size;
          burst_d = master_ar_burst;
          side_d  = master_ar_side;
          rem_d   = {1'b0, master_ar_len} + 9'd1;
          addr_d  = master_ar_addr;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (slave_ar_ready) begin
          rem_d   = rem_q - beats;
          addr_d  = addr_q + (ADDR_WIDTH'(beats) << size_q);
          final_d = (rem_q == beats);
          state_d = S_R;
        end
      end
      S_R: begin
        if (slave_r_valid && master_r_ready && slave_r_last)
          state_d = final_q ? S_IDLE : S_AR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      size_q  <= '0;
      burst_q <= '0;
      side_q  <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      side_q  <= side_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      final_q <= final_d;
    end
  end

  // A FIXED/WRAP burst cannot be split, so it must already fit downstream.
  always_ff @(posedge clk) begin
    if (rstn && state_q == S_IDLE && master_ar_valid && master_ar_burst != BURST_INCR)
      assert ({1'b0, master_ar_len} < MAX_B)
        else $fatal(1, "non-INCR burst longer than MAX_BEATS");
  end

endmodule

// File: tb/tb_nasti_read_burst_splitter.sv
// Directed and randomized read bursts against a queue-based sub-burst plan and beat-index data model.
module tb_nasti_read_burst_splitter;
  localparam int IDW = 2, AW = 32, DW = 64, UW = 1, MAXB = 4, SW = 15 + UW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [IDW-1:0] master_ar_id = '0;
  logic [AW-1:0]  master_ar_addr = '0;
  logic [7:0]     master_ar_len = '0;
  logic [2:0]     master_ar_size = '0;
  logic [1:0]     master_ar_burst = '0;
  logic [SW-1:0]  master_ar_side = '0;
  logic           master_ar_valid = 1'b0;
  logic           master_ar_ready;
  logic [IDW-1:0] master_r_id;
  logic [DW-1:0]  master_r_data;
  logic [1:0]     master_r_resp;
  logic           master_r_last;
  logic           master_r_valid;
  logic           master_r_ready = 1'b0;
  logic [IDW-1:0] slave_ar_id;
  logic [AW-1:0]  slave_ar_addr;
  logic [7:0]     slave_ar_len;
  logic [2:0]     slave_ar_size;
  logic [1:0]     slave_ar_burst;
  logic [SW-1:0]  slave_ar_side;
  logic           slave_ar_valid;
  logic           slave_ar_ready = 1'b0;
  logic [DW-1:0]  slave_r_data = '0;
  logic [1:0]     slave_r_resp = '0;
  logic           slave_r_last = 1'b0;
  logic           slave_r_valid = 1'b0;
  logic           slave_r_ready;

  nasti_read_burst_splitter #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rstn(rstn),
    .master_ar_id(master_ar_id), .master_ar_addr(master_ar_addr), .master_ar_len(master_ar_len),
    .master_ar_size(master_ar_size), .master_ar_burst(master_ar_burst), .master_ar_side(master_ar_side),
    .master_ar_valid(master_ar_valid), .master_ar_ready(master_ar_ready),
    .master_r_id(master_r_id), .master_r_data(master_r_data), .master_r_resp(master_r_resp),
    .master_r_last(master_r_last), .master_r_valid(master_r_valid), .master_r_ready(master_r_ready),
    .slave_ar_id(slave_ar_id), .slave_ar_addr(slave_ar_addr), .slave_ar_len(slave_ar_len),
    .slave_ar_size(slave_ar_size), .slave_ar_burst(slave_ar_burst), .slave_ar_side(slave_ar_side),
    .slave_ar_valid(slave_ar_valid), .slave_ar_ready(slave_ar_ready),
    .slave_r_data(slave_r_data), .slave_r_resp(slave_r_resp), .slave_r_last(slave_r_last),
    .slave_r_valid(slave_r_valid), .slave_r_ready(slave_r_ready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int txn_no = 0;
  logic [AW-1:0] plan_addr[$];
  int            plan_len[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input int t, input int i);
    return {32'(t) ^ 32'h5EED0000, 32'(i) ^ 32'hBEEF0000};
  endfunction

  // Expected slave-side sub-bursts, derived directly from the splitting rules.
  task automatic build_plan(input logic [AW-1:0] addr, input int len, input int size,
                            input logic [1:0] burst);
    int rem, b, lim;
    logic [AW-1:0] a;
    plan_addr.delete();
    plan_len.delete();
    rem = len + 1;
    a = addr;
    if (burst != 2'b01) begin
      plan_addr.push_back(a);
      plan_len.push_back(len);
      return;
    end
    while (rem > 0) begin
      b = (rem < MAXB) ? rem : MAXB;
`ifdef SPLIT_4K_EN
      lim = (4096 - int'(a[11:0])) >> size;
      if (b > lim) b = lim;
`else
      lim = b;
`endif
      plan_addr.push_back(a);
      plan_len.push_back(b - 1);
      a = a + AW'(b << size);
      rem -= b;
    end
  endtask

  task automatic run_txn(input logic [AW-1:0] addr, input int len, input int size,
                         input logic [1:0] burst, input int ar_stall, input bit rnd,
                         input int err_beat, input int abort_beat);
    logic [IDW-1:0] id;
    logic [SW-1:0]  side;
    int total, beat, ars_seen, sub_left, cyc, stall_left;
    bit expect_ar_now, done, aborted;
    txn_no++;
    id = IDW'($urandom);
    side = SW'($urandom);
    build_plan(addr, len, size, burst);
    total = len + 1;
    beat = 0; ars_seen = 0; sub_left = 0; cyc = 0; stall_left = ar_stall;
    expect_ar_now = 0; done = 0; aborted = 0;
    @(negedge clk);
    master_ar_id = id; master_ar_addr = addr; master_ar_len = 8'(len);
    master_ar_size = 3'(size); master_ar_burst = burst; master_ar_side = side;
    master_ar_valid = 1'b1;
    #1 chk("idle_ar_ready", 64'(master_ar_ready), 64'd1);
    @(negedge clk);
    master_ar_valid = 1'b0;
    while (!done && cyc < 3000) begin
      slave_ar_ready = (stall_left > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      master_r_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      slave_r_valid  = (sub_left > 0) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      slave_r_data   = data_of(txn_no, beat);
      slave_r_resp   = (beat == err_beat) ? 2'd2 : 2'd0;
      slave_r_last   = (sub_left == 1);
      #1;
      chk("busy_ar_ready", 64'(master_ar_ready), 64'd0);
      chk("r_valid_pass", 64'(master_r_valid), 64'(slave_r_valid));
      chk("r_ready_pass", 64'(slave_r_ready), 64'((sub_left > 0) ? master_r_ready : 1'b0));
      if (expect_ar_now) chk("ar_next_cycle", 64'(slave_ar_valid), 64'd1);
      expect_ar_now = 0;
      if (slave_ar_valid) begin
        chk("ar_excess", 64'(ars_seen < plan_addr.size()), 64'd1);
        if (ars_seen < plan_addr.size()) begin
          chk("ar_addr", 64'(slave_ar_addr), 64'(plan_addr[ars_seen]));
          chk("ar_len", 64'(slave_ar_len), 64'(plan_len[ars_seen]));
          chk("ar_id", 64'(slave_ar_id), 64'(id));
          chk("ar_size", 64'(slave_ar_size), 64'(size));
          chk("ar_burst", 64'(slave_ar_burst), 64'(burst));
          chk("ar_side", 64'(slave_ar_side), 64'(side));
          if (slave_ar_ready) begin
            sub_left = plan_len[ars_seen] + 1;
            ars_seen++;
          end
        end
        if (stall_left > 0) stall_left--;
      end
      if (master_r_valid && master_r_ready) begin
        chk("r_data", master_r_data, data_of(txn_no, beat));
        chk("r_resp", 64'(master_r_resp), (beat == err_beat) ? 64'd2 : 64'd0);
        chk("r_id", 64'(master_r_id), 64'(id));
        chk("r_last", 64'(master_r_last), 64'(beat == total - 1));
        beat++;
        sub_left--;
        if (sub_left == 0 && beat < total) expect_ar_now = 1;
        if (beat == total) done = 1;
        if (beat == abort_beat) begin
          done = 1;
          aborted = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("txn_timeout", 64'(cyc < 3000), 64'd1);
    if (aborted) begin
      rstn = 1'b0;
      slave_r_valid = 1'b1; slave_r_last = 1'b1; slave_ar_ready = 1'b1; master_r_ready = 1'b1;
      #1;
      chk("rst_ar_valid", 64'(slave_ar_valid), 64'd0);
      chk("rst_r_valid", 64'(master_r_valid), 64'd0);
      chk("rst_r_last", 64'(master_r_last), 64'd0);
      chk("rst_ar_ready", 64'(master_ar_ready), 64'd1);
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("post_rst_ar_valid", 64'(slave_ar_valid), 64'd0);
        chk("post_rst_r_valid", 64'(master_r_valid), 64'd0);
        @(negedge clk);
      end
    end else begin
      #1;
      chk("done_ar_ready", 64'(master_ar_ready), 64'd1);
      chk("beats_delivered", 64'(beat), 64'(total));
      chk("ar_count", 64'(ars_seen), 64'(plan_addr.size()));
    end
    slave_r_valid = 1'b0; slave_r_last = 1'b0; slave_ar_ready = 1'b0; master_r_ready = 1'b0;
  endtask

  initial begin
    int sz, ln;
    logic [AW-1:0] ad;
    slave_r_valid = 1'b1;
    slave_r_last = 1'b1;
    master_r_ready = 1'b1;
    #12;
    chk("reset_ar_ready", 64'(master_ar_ready), 64'd1);
    chk("reset_ar_valid", 64'(slave_ar_valid), 64'd0);
    chk("reset_r_valid", 64'(master_r_valid), 64'd0);
    chk("reset_r_last", 64'(master_r_last), 64'd0);
    slave_r_valid = 1'b0; slave_r_last = 1'b0; master_r_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    run_txn(32'h0000_1000, 15, 3, 2'b01, 0, 1'b0, -1, -1);
    run_txn(32'h0000_2000, 2, 3, 2'b01, 0, 1'b0, -1, -1);
    run_txn(32'h0000_3000, 15, 3, 2'b01, 5, 1'b1, -1, -1);
    run_txn(32'h0000_0FF0, 3, 3, 2'b01, 0, 1'b0, -1, -1);
    run_txn(32'h0000_1000, 15, 3, 2'b01, 0, 1'b1, 4, -1);
    run_txn(32'h0000_1000, 15, 3, 2'b01, 0, 1'b0, -1, 6);
    run_txn(32'h0000_4000, 7, 2, 2'b01, 0, 1'b0, -1, -1);
    run_txn(32'h0000_5000, 3, 2, 2'b00, 0, 1'b1, 1, -1);
    run_txn(32'h0000_5100, 1, 3, 2'b10, 0, 1'b1, -1, -1);
    run_txn(32'hFFFF_FFE0, 7, 3, 2'b01, 0, 1'b1, -1, -1);
    run_txn(32'h0000_0000, 0, 0, 2'b01, 2, 1'b1, 0, -1);

    for (int t = 0; t < 25; t++) begin
      sz = int'($urandom_range(0, 3));
      ad = AW'($urandom) & ~((AW'(1) << sz) - AW'(1));
      ln = int'($urandom_range(0, 40));
      run_txn(ad, ln, sz, 2'b01, int'($urandom_range(0, 3)), 1'b1,
              int'($urandom_range(0, 45)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
